draw_line_brush: RTL and testbench
==================================

DRAW_LINE_BRUSH -- requirements
Module: draw_line_brush

Interface
REQ-001 Parameter COORD_W, default 10, coordinate width in bits.
REQ-002 Parameter X_MAX, default 799, largest drawable X; pixels with X > X_MAX are clipped.
REQ-003 Parameter Y_MAX, default 599, largest drawable Y; pixels with Y > Y_MAX are clipped.
REQ-004 Parameter R_MAX, default 7, largest brush radius accepted; R_MAX < 16.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 i_valid  in  1  stroke request valid.
REQ-008 i_ready  out  1  block can accept a stroke; equals 1 only in IDLE.
REQ-009 i_x0, i_y0, i_x1, i_y1  in  COORD_W each  stroke start and end points, unsigned.
REQ-010 i_radius  in  4  brush half-width r; the stamp is a (2r+1)x(2r+1) square.
REQ-011 o_valid  out  1  o_x/o_y hold a pixel to draw.
REQ-012 o_ready  in  1  consumer accepts the pixel when o_valid && o_ready.
REQ-013 o_x, o_y  out  COORD_W each  pixel coordinate.
REQ-014 o_done  out  1  one-cycle pulse at stroke completion.
REQ-015 i_abort  in  1  cancels the current stroke.

Function
REQ-016 States: IDLE, SETUP, STAMP, STEP, FIN; reset enters IDLE.
REQ-017 IDLE: on i_valid && i_ready, latch the inputs and go to SETUP. The latched radius is min(i_radius, R_MAX).
REQ-018 SETUP (1 cycle): compute dx=|x1-x0|, dy=-|y1-y0|, sx/sy=+1/-1 (+1 when equal), err=dx+dy, and the centre (cx,cy)=(x0,y0). Then go to STAMP.
REQ-019 err and e2 are signed, COORD_W+2 bits wide; stamp offsets and clip tests are signed, COORD_W+2 bits wide; no overflow is permitted.
REQ-020 STAMP: walk offsets (ox,oy), each in -r..+r, in raster order (oy outer, ox inner, both ascending), one candidate per cycle.
REQ-021 A candidate (cx+ox, cy+oy) outside [0,X_MAX]x[0,Y_MAX] is skipped: it occupies one cycle with o_valid=0 and is never output.
REQ-022 For an in-range candidate, assert o_valid. o_x, o_y and o_valid hold stable until o_ready=1, then advance to the next candidate.
REQ-023 After the last offset (+r,+r) is accepted or skipped: go to FIN if (cx,cy)==(x1,y1), otherwise go to STEP.
REQ-024 STEP (1 cycle, o_valid=0): e2=2*err.
- If e2>=dy: err+=dy and cx+=sx.
- If e2<=dx: err+=dx and cy+=sy.
- Both conditions use the pre-update err.
- Then return to STAMP.
REQ-025 Duplicate pixels from overlapping stamps are emitted as-is; no de-duplication.
REQ-026 FIN: o_done=1 for exactly one cycle, then IDLE. i_ready rises the cycle after o_done.
REQ-027 Latency: the first candidate is presented 2 cycles after the accept edge. With o_ready=1 and no clipping, each pixel takes 1 cycle and each centre step adds 1 cycle.
REQ-028 A single-point stroke (x0,y0)==(x1,y1) emits exactly one stamp and no STEP.
REQ-029 i_abort=1 in any non-IDLE state:
- next cycle: IDLE, o_valid=0, o_done=0;
- any pending pixel is dropped.
- i_abort is ignored in IDLE.
REQ-030 i_abort and o_ready may both be 1 in the same cycle: the pixel counts as accepted, and abort still takes effect.
REQ-031 i_valid while not in IDLE is ignored; no request is queued.
REQ-032 If every candidate of a stroke is clipped, the stroke still completes with o_done and no o_valid.

Reset
REQ-033 rst=0 at a clock edge forces IDLE with o_valid=0, o_done=0, o_x=0, o_y=0, and all internal registers cleared.
REQ-034 Reset mid-stroke abandons the stroke without o_done. After reset, i_ready=1 in the first cycle with rst=1.

Verification
REQ-035 Line (2,5)->(5,5), r=0, o_ready=1 -> outputs (2,5),(3,5),(4,5),(5,5), then a single o_done pulse.
REQ-036 Point (10,10)->(10,10), r=1 -> 9 pixels (9,9),(10,9),(11,9),(9,10),…,(11,11), then o_done.
REQ-037 Point (0,0), r=1 -> only (0,0),(1,0),(0,1),(1,1) are output; point (799,599), r=1 -> only (798,598),(799,598),(798,599),(799,599).
REQ-038 Diagonal (3,3)->(0,0), r=0 -> (3,3),(2,2),(1,1),(0,0); steep line (0,0)->(1,3), r=0 -> (0,0),(0,1),(1,2),(1,3).
REQ-039 Backpressure: line (2,5)->(5,5) with o_ready toggling 1,0,0,1,… -> same 4 pixels, each held stable while stalled, nothing lost or duplicated.
REQ-040 Abort and reset:
- i_abort asserted on the 2nd output of the REQ-035 stroke -> o_valid=0 next cycle, no o_done, i_ready=1.
- rst=0 mid-stroke -> same result with o_x=o_y=0.
- i_radius=15 with R_MAX=7 -> 225 pixels per stamp.

Source files
------------

// File: rtl/draw_line_brush.sv
`default_nettype none
// draw_line_brush: walks a Bresenham line and emits a clipped (2r+1)x(2r+1) brush stamp at every centre.
// Rev 1.0
module draw_line_brush #(
  parameter int COORD_W = 10,
  parameter int X_MAX   = 799,
  parameter int Y_MAX   = 599,
  parameter int R_MAX   = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [COORD_W-1:0] i_x0,
  input  logic [COORD_W-1:0] i_y0,
  input  logic [COORD_W-1:0] i_x1,
  input  logic [COORD_W-1:0] i_y1,
  input  logic [3:0]         i_radius,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_done,
  input  logic               i_abort
);

  localparam int SW = COORD_W + 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_STAMP = 3'd2;
  localparam logic [2:0] S_STEP  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [3:0]           R_LIM = 4'(R_MAX);
  localparam logic signed [SW-1:0] X_LIM = SW'(X_MAX);
  localparam logic signed [SW-1:0] Y_LIM = SW'(Y_MAX);
  localparam logic signed [SW-1:0] S_ONE = SW'(1);

  logic [2:0]               state_q, state_d;
  logic [COORD_W-1:0]       cx_q, cx_d, cy_q, cy_d, x1_q, x1_d, y1_q, y1_d;
  logic [3:0]               r_q, r_d;
  logic signed [SW-1:0]     dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic signed [SW-1:0]     ox_q, ox_d, oy_q, oy_d;
  logic                     sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;

  logic signed [SW-1:0]     r_s, px, py, e2, err_tmp, adx_s, ady_s;
  logic [COORD_W-1:0]       adx, ady;
  logic                     in_range, last_off, at_end, adv;

  assign r_s      = $signed({{(SW-4){1'b0}}, r_q});
  assign px       = $signed({2'b00, cx_q}) + ox_q;
  assign py       = $signed({2'b00, cy_q}) + oy_q;
  assign in_range = !px[SW-1] && !py[SW-1] && (px <= X_LIM) && (py <= Y_LIM);
  assign last_off = (ox_q == r_s) && (oy_q == r_s);
  assign at_end   = (cx_q == x1_q) && (cy_q == y1_q);
  // A clipped candidate always advances; a visible one waits for the consumer.
  assign adv      = !in_range || o_ready;
  assign adx      = (x1_q >= cx_q) ? (x1_q - cx_q) : (cx_q - x1_q);
  assign ady      = (y1_q >= cy_q) ? (y1_q - cy_q) : (cy_q - y1_q);
  assign adx_s    = $signed({2'b00, adx});
  assign ady_s    = $signed({2'b00, ady});
  assign e2       = err_q <<< 1;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_valid) state_d = S_SETUP;
      S_SETUP: state_d = S_STAMP;
      S_STAMP: if (adv && last_off) state_d = at_end ? S_FIN : S_STEP;
      S_STEP:  state_d = S_STAMP;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (i_abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  always_comb begin
    o_valid = (state_q == S_STAMP) && in_range;
    o_x     = o_valid ? px[COORD_W-1:0] : '0;
    o_y     = o_valid ? py[COORD_W-1:0] : '0;
    o_done  = (state_q == S_FIN);
    i_ready = (state_q == S_IDLE);
  end

  always_comb begin
    cx_d     = cx_q;
    cy_d     = cy_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    r_d      = r_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    err_tmp  = err_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          cx_d = i_x0;
          cy_d = i_y0;
          x1_d = i_x1;
          y1_d = i_y1;
          r_d  = (i_radius > R_LIM) ? R_LIM : i_radius;
        end
      end
      S_SETUP: begin
        dx_d     = adx_s;
        dy_d     = -ady_s;
        err_d    = adx_s - ady_s;
        sx_neg_d = (x1_q < cx_q);
        sy_neg_d = (y1_q < cy_q);
        ox_d     = -r_s;
        oy_d     = -r_s;
      end
      S_STAMP: begin
        if (adv && !last_off) begin
          if (ox_q == r_s) begin
            ox_d = -r_s;
            oy_d = oy_q + S_ONE;
          end else begin
            ox_d = ox_q + S_ONE;
          end
        end
      end
      S_STEP: begin
        // Both tests use the error value from before this step.
        if (e2 >= dy_q) begin
          err_tmp = err_tmp + dy_q;
          cx_d    = sx_neg_q ? (cx_q - COORD_W'(1)) : (cx_q + COORD_W'(1));
        end
        if (e2 <= dx_q) begin
          err_tmp = err_tmp + dx_q;
          cy_d    = sy_neg_q ? (cy_q - COORD_W'(1)) : (cy_q + COORD_W'(1));
        end
        err_d = err_tmp;
        ox_d  = -r_s;
        oy_d  = -r_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cx_q     <= '0;
      cy_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      r_q      <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else begin
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      r_q      <= r_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_draw_line_brush.sv
`default_nettype none
// tb_draw_line_brush: directed and randomized strokes checked against a behavioural line/stamp model.
// Rev 1.0
module tb_draw_line_brush;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_abort = 1'b0;
  logic          o_ready = 1'b0;
  logic [CW-1:0] i_x0 = '0, i_y0 = '0, i_x1 = '0, i_y1 = '0;
  logic [3:0]    i_radius = '0;
  logic          i_ready, o_valid, o_done;
  logic [CW-1:0] o_x, o_y;

  draw_line_brush dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
    .i_x0(i_x0), .i_y0(i_y0), .i_x1(i_x1), .i_y1(i_y1), .i_radius(i_radius),
    .o_valid(o_valid), .o_ready(o_ready), .o_x(o_x), .o_y(o_y),
    .o_done(o_done), .i_abort(i_abort)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int got_x[$], got_y[$], exp_x[$], exp_y[$];
  int done_cnt, first_valid_cyc, done_cyc, stall_err, exp_centres;
  bit timed_out;

  // Reference: Bresenham centres, each stamped in raster order with screen clipping.
  task automatic model(input int x0, input int y0, input int x1, input int y1, input int r);
    int dx, dy, sx, sy, err, e2, x, y, rr;
    exp_x.delete(); exp_y.delete(); exp_centres = 0;
    rr  = (r > 7) ? 7 : r;
    dx  = (x1 >= x0) ? x1 - x0 : x0 - x1;
    dy  = -((y1 >= y0) ? y1 - y0 : y0 - y1);
    sx  = (x1 >= x0) ? 1 : -1;
    sy  = (y1 >= y0) ? 1 : -1;
    err = dx + dy;
    x = x0; y = y0;
    while (1) begin
      exp_centres++;
      for (int oy = -rr; oy <= rr; oy++)
        for (int ox = -rr; ox <= rr; ox++)
          if (x + ox >= 0 && x + ox <= 799 && y + oy >= 0 && y + oy <= 599) begin
            exp_x.push_back(x + ox);
            exp_y.push_back(y + oy);
          end
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  function automatic int first_diff();
    int n = (got_x.size() < exp_x.size()) ? got_x.size() : exp_x.size();
    for (int i = 0; i < n; i++)
      if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) return i;
    if (got_x.size() != exp_x.size()) return n;
    return -1;
  endfunction

  // Drives one stroke and records accepted pixels; called at #1 after a rising edge with the DUT idle.
  task automatic run_stroke(input int x0, input int y0, input int x1, input int y1, input int r,
                            input int bp, input int stop_at, input bit use_rst, input bit busy_valid);
    bit pv, pr, rdy, stop_now;
    int ppx, ppy, cyc;
    got_x.delete(); got_y.delete();
    done_cnt = 0; first_valid_cyc = -1; done_cyc = -1; stall_err = 0; timed_out = 0;
    i_x0 = x0[CW-1:0]; i_y0 = y0[CW-1:0]; i_x1 = x1[CW-1:0]; i_y1 = y1[CW-1:0];
    i_radius = r[3:0]; i_valid = 1'b1;
    @(posedge clk); #1;
    if (busy_valid) begin
      i_x0 = CW'($urandom); i_y0 = CW'($urandom); i_x1 = CW'($urandom); i_y1 = CW'($urandom);
    end else begin
      i_valid = 1'b0;
    end
    cyc = 1; pv = 0; pr = 0; ppx = 0; ppy = 0;
    while (cyc < 20000) begin
      case (bp)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc - 2) % 3) == 0;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      o_ready = rdy;
      if (pv && !pr && !(o_valid === 1'b1 && o_x == ppx && o_y == ppy)) stall_err++;
      if (o_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      stop_now = (stop_at >= 0) && (o_valid === 1'b1) && (got_x.size() == stop_at);
      if (o_valid === 1'b1 && rdy) begin
        got_x.push_back(int'(o_x));
        got_y.push_back(int'(o_y));
      end
      if (o_done === 1'b1) begin
        done_cnt++; done_cyc = cyc; i_valid = 1'b0;
        @(posedge clk); #1;
        o_ready = 1'b0;
        return;
      end
      if (stop_now) begin
        if (use_rst) rst = 1'b0;
        else         i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0; o_ready = 1'b0; i_valid = 1'b0;
        return;
      end
      pv = o_valid; pr = rdy; ppx = int'(o_x); ppy = int'(o_y);
      @(posedge clk); #1;
      cyc++;
    end
    timed_out = 1; i_valid = 1'b0; o_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; i_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
    n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_o_done: got %b want 0", o_done); end
    n_checks++; if (o_x !== '0 || o_y !== '0) begin n_fail++; $display("FAIL reset_xy: got (%0d,%0d) want (0,0)", o_x, o_y); end
    rst = 1'b1; i_valid = 1'b0;
    n_checks++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL reset_i_ready: got %b want 1", i_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_line();
    int lx[4] = '{2, 3, 4, 5};
    int bad = 0;
    model(2, 5, 5, 5, 0);
    run_stroke(2, 5, 5, 5, 0, 0, -1, 0, 0);
    for (int i = 0; i < 4; i++)
      if (got_x.size() != 4 || got_x[i] != lx[i] || got_y[i] != 5) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL line_pixels: got %0d pixels, %0d wrong, want (2..5,5)", got_x.size(), bad); end
    n_checks++; if (first_diff() != -1) begin n_fail++; $display("FAIL line_model: diff at %0d want none", first_diff()); end
    n_checks++; if (first_valid_cyc != 2) begin n_fail++; $display("FAIL line_latency: got %0d want 2", first_valid_cyc); end
    n_checks++; if (done_cnt != 1 || done_cyc != 9) begin n_fail++; $display("FAIL line_done: got cnt %0d cyc %0d want 1 at 9", done_cnt, done_cyc); end
    n_checks++; if (o_done !== 1'b0 || i_ready !== 1'b1) begin n_fail++; $display("FAIL line_after_done: got done %b ready %b want 0 1", o_done, i_ready); end
  endtask

  task automatic test_point();
    model(10, 10, 10, 10, 1);
    run_stroke(10, 10, 10, 10, 1, 0, -1, 0, 0);
    n_checks++; if (got_x.size() != 9 || got_x[0] != 9 || got_y[0] != 9 || got_x[8] != 11 || got_y[8] != 11) begin
      n_fail++; $display("FAIL point_pixels: got %0d pixels want 9 from (9,9) to (11,11)", got_x.size()); end
    n_checks++; if (first_diff() != -1 || exp_centres != 1) begin n_fail++; $display("FAIL point_model: diff at %0d want none", first_diff()); end
    n_checks++; if (done_cnt != 1 || done_cyc != 11) begin n_fail++; $display("FAIL point_done: got cnt %0d cyc %0d want 1 at 11", done_cnt, done_cyc); end
  endtask

  task automatic test_clip();
    model(0, 0, 0, 0, 1);
    run_stroke(0, 0, 0, 0, 1, 0, -1, 0, 0);
    n_checks++; if (got_x.size() != 4 || got_x[0] != 0 || got_y[0] != 0 || got_x[3] != 1 || got_y[3] != 1 || first_diff() != -1) begin
      n_fail++; $display("FAIL clip_origin: got %0d pixels diff at %0d want 4 (0,0)..(1,1)", got_x.size(), first_diff()); end
    model(799, 599, 799, 599, 1);
    run_stroke(799, 599, 799, 599, 1, 0, -1, 0, 0);
    n_checks++; if (got_x.size() != 4 || got_x[0] != 798 || got_y[0] != 598 || got_x[3] != 799 || got_y[3] != 599 || first_diff() != -1) begin
      n_fail++; $display("FAIL clip_corner: got %0d pixels diff at %0d want 4 (798,598)..(799,599)", got_x.size(), first_diff()); end
    run_stroke(900, 700, 902, 701, 2, 0, -1, 0, 0);
    n_checks++; if (got_x.size() != 0 || done_cnt != 1 || first_valid_cyc != -1) begin
      n_fail++; $display("FAIL clip_all: got %0d pixels done %0d want 0 pixels done 1", got_x.size(), done_cnt); end
  endtask

  task automatic test_diag();
    model(3, 3, 0, 0, 0);
    run_stroke(3, 3, 0, 0, 0, 0, -1, 0, 0);
    n_checks++; if (got_x.size() != 4 || got_x[1] != 2 || got_y[1] != 2 || got_x[3] != 0 || first_diff() != -1) begin
      n_fail++; $display("FAIL diag: got %0d pixels diff at %0d want (3,3),(2,2),(1,1),(0,0)", got_x.size(), first_diff()); end
    model(0, 0, 1, 3, 0);
    run_stroke(0, 0, 1, 3, 0, 0, -1, 0, 0);
    n_checks++; if (got_x.size() != 4 || got_x[1] != 0 || got_y[1] != 1 || got_x[2] != 1 || got_y[2] != 2 || first_diff() != -1) begin
      n_fail++; $display("FAIL steep: got %0d pixels diff at %0d want (0,0),(0,1),(1,2),(1,3)", got_x.size(), first_diff()); end
  endtask

  task automatic test_backpressure();
    model(2, 5, 5, 5, 0);
    run_stroke(2, 5, 5, 5, 0, 1, -1, 0, 0);
    n_checks++; if (first_diff() != -1 || got_x.size() != 4) begin n_fail++; $display("FAIL bp_pixels: got %0d diff at %0d want 4 none", got_x.size(), first_diff()); end
    n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_err); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_abort();
    int extra = 0;
    run_stroke(2, 5, 5, 5, 0, 0, 1, 0, 0);
    n_checks++; if (o_valid !== 1'b0 || o_done !== 1'b0 || i_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_state: got valid %b done %b ready %b want 0 0 1", o_valid, o_done, i_ready); end
    n_checks++; if (got_x.size() != 2) begin n_fail++; $display("FAIL abort_count: got %0d want 2", got_x.size()); end
    repeat (12) begin @(posedge clk); #1; if (o_valid !== 1'b0 || o_done !== 1'b0) extra++; end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL abort_quiet: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_reset_mid();
    int extra = 0;
    run_stroke(2, 5, 5, 5, 0, 0, 1, 1, 0);
    n_checks++; if (o_valid !== 1'b0 || o_done !== 1'b0 || o_x !== '0 || o_y !== '0) begin
      n_fail++; $display("FAIL rst_mid_state: got valid %b done %b (%0d,%0d) want 0 0 (0,0)", o_valid, o_done, o_x, o_y); end
    rst = 1'b1;
    n_checks++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", i_ready); end
    repeat (12) begin @(posedge clk); #1; if (o_valid !== 1'b0 || o_done !== 1'b0) extra++; end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL rst_mid_quiet: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_radius_clamp();
    model(100, 100, 100, 100, 15);
    run_stroke(100, 100, 100, 100, 15, 0, -1, 0, 0);
    n_checks++; if (got_x.size() != 225 || first_diff() != -1) begin
      n_fail++; $display("FAIL radius_clamp: got %0d pixels diff at %0d want 225", got_x.size(), first_diff()); end
  endtask

  task automatic test_busy_valid();
    int extra = 0;
    model(20, 20, 22, 21, 1);
    run_stroke(20, 20, 22, 21, 1, 0, -1, 0, 1);
    n_checks++; if (first_diff() != -1 || done_cnt != 1) begin n_fail++; $display("FAIL busy_pixels: diff at %0d done %0d want none 1", first_diff(), done_cnt); end
    repeat (4) begin @(posedge clk); #1; if (o_valid !== 1'b0 || i_ready !== 1'b1) extra++; end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL busy_no_queue: got %0d active cycles want 0", extra); end
  endtask

  function automatic int pick(input int lim);
    int s = int'($urandom_range(0, 3));
    case (s)
      0:       return int'($urandom_range(0, 6));
      1:       return lim - 4 + int'($urandom_range(0, 8));
      2:       return int'($urandom_range(lim + 1, 1023));
      default: return int'($urandom_range(0, 1023));
    endcase
  endfunction

  task automatic test_random();
    int x0, y0, x1, y1, r, bp;
    for (int n = 0; n < 12; n++) begin
      x0 = pick(799); y0 = pick(599);
      x1 = x0 + int'($urandom_range(0, 10)) - 5; if (x1 < 0) x1 = 0; if (x1 > 1023) x1 = 1023;
      y1 = y0 + int'($urandom_range(0, 10)) - 5; if (y1 < 0) y1 = 0; if (y1 > 1023) y1 = 1023;
      r  = int'($urandom_range(0, 15));
      bp = int'($urandom_range(0, 2));
      model(x0, y0, x1, y1, r);
      run_stroke(x0, y0, x1, y1, r, bp, -1, 0, 0);
      n_checks++; if (first_diff() != -1 || done_cnt != 1 || stall_err != 0) begin
        n_fail++;
        $display("FAIL random_%0d (%0d,%0d)->(%0d,%0d) r%0d: got %0d px diff %0d done %0d stall %0d want %0d px done 1",
                 n, x0, y0, x1, y1, r, got_x.size(), first_diff(), done_cnt, stall_err, exp_x.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_point();
    test_clip();
    test_diag();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_radius_clamp();
    test_busy_valid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
